cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the 8-state microcycle counter. It consumes the 3-bit cycle value (0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3).
- Owns the 12-bit program counter and drives the multiplexed ROM address nibbles during A1–A3.
- Captures OPR/OPA from ROM during M1/M2 and assembles one-word and two-word instructions.
- Presents each complete instruction to the decoder with a one-cycle valid strobe at X1.

Parameters:
PC_RESET, 12'h000, program counter value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cycle  input  3  microcycle index from the cycle counter, 0..7
romData  input  4  ROM data nibble; valid during cycles 3 and 4
jumpEn  input  1  execute stage requests PC load; sampled only at cycle 7
jumpAddr  input  12  PC load target; sampled with jumpEn
pc  output  12  current program counter
addrNibble  output  4  ROM address nibble for the current A-cycle
syncOut  output  1  high while cycle==7; marks the next A1
opr  output  4  first-word opcode nibble
opa  output  4  first-word operand nibble
word2  output  8  second word of a two-word instruction, {OPR,OPA}
twoWord  output  1  held instruction is two-word
instrValid  output  1  one-cycle strobe: opr/opa/word2/twoWord complete

Behaviour:
- Reset (rst high at a clock edge):
  - pc <= PC_RESET.
  - opr, opa, word2 <= 0; twoWord, instrValid <= 0.
  - Internal secondPending <= 0.
  - Reset overrides every other update in the same cycle; a reset mid-instruction abandons any pending second word.
- Combinational outputs (no added latency):
  - addrNibble = pc[3:0] at cycle 0, pc[7:4] at cycle 1, pc[11:8] at cycle 2, 4'h0 at cycles 3..7.
  - syncOut = (cycle==7).
- Cycle 3 edge:
  - secondPending==0: opr <= romData.
  - secondPending==1: word2[7:4] <= romData.
- Cycle 4 edge:
  - secondPending==0: opa <= romData.
  - secondPending==1: word2[3:0] <= romData.
- Two-word detection uses the first word's OPR/OPA and is evaluated at the cycle 4 edge:
  - 0001 JCN, 0100 JUN, 0101 JMS, 0111 ISZ are two-word.
  - 0010 with OPA[0]==0 (FIM) is two-word.
  - All other codes, including FIN, are one-word.
- When a first word is two-word: twoWord <= 1 and secondPending <= 1 at the cycle 4 edge. When a first word is one-word: twoWord <= 0.
- instrValid is registered and is high for exactly the cycle in which cycle==5:
  - one-word instruction: in that instruction's own cycle.
  - two-word instruction: in the instruction cycle that fetched the second word. secondPending clears at that cycle-5 edge.
  - first word of a two-word instruction: instrValid stays low.
- PC update, at the cycle 7 edge only:
  - jumpEn==1: pc <= jumpAddr, and secondPending <= 0 (pending second word flushed).
  - otherwise: pc <= pc + 1, modulo 4096 (12'hFFF wraps to 12'h000).
- jumpEn and jumpAddr are ignored at cycles 0..6.
- opr, opa, word2 and twoWord hold their values from capture until the next capture.
- The block follows the cycle value only. Repeated or skipped cycle values cause no internal checking; each edge acts on the current value.

Test Plan:
- Reset then run 8 cycles with ROM at 0x000 = 0xD5 (LDM 5) → addrNibble 0,0,0 during A1–A3; instrValid high once at cycle 5 with opr=D, opa=5, twoWord=0; pc=0x001 after cycle 7.
- ROM 0x010 = 0x40, 0x011 = 0x23 (JUN 023) → no instrValid in the first instruction cycle. In the second: instrValid with opr=4, opa=0, word2=0x23, twoWord=1. Assert jumpEn with jumpAddr=0x023 at cycle 7 → pc=0x023.
- pc=0xFFF, fetch of a one-word instruction → addrNibble F,F,F; pc=0x000 after cycle 7.
- jumpEn=1 held at cycles 0..6 with jumpAddr=0x5A5 → pc unchanged. Same at cycle 7 → pc=0x5A5; addrNibble 5,A,5 in the next A1–A3.
- FIM (opr=2, opa=4) at first word, then jumpEn at cycle 7 → secondPending flushed. The next fetch at jumpAddr is treated as a first word (opr updated, instrValid at its cycle 5).
- rst asserted at cycle 4 of a JMS first word → all outputs zero and pc=PC_RESET next cycle. After release the first fetched word is a new first word.

Source files
------------

// File: rtl/cpu_fetch_unit.sv
// Fetch stage: drives ROM address nibbles in A1-A3, captures OPR/OPA in M1/M2, and assembles one- and two-word instructions.
// addrNibble/syncOut are combinational; the instrValid strobe is registered and lands in X1. There is no backpressure: the block follows the cycle value.
module cpu_fetch_unit #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cycle,
  input  logic [3:0]  romData,
  input  logic        jumpEn,
  input  logic [11:0] jumpAddr,
  output logic [11:0] pc,
  output logic [3:0]  addrNibble,
  output logic        syncOut,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [7:0]  word2,
  output logic        twoWord,
  output logic        instrValid
);

  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X3 = 3'd7;

  logic secondPending;
  logic firstIsTwo;

  function automatic logic isTwoWord(input logic [3:0] code, input logic [3:0] operand);
    logic r;
    r = 1'b0;
    case (code)
      4'h1, 4'h4, 4'h5, 4'h7: r = 1'b1;
      4'h2:                   r = ~operand[0];   // FIM; FIN (odd OPA) is one-word
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // OPR was latched at M1; OPA is still on the bus at the M2 edge.
  assign firstIsTwo = isTwoWord(opr, romData);

  always_comb begin
    addrNibble = 4'h0;
    case (cycle)
      CYC_A1:  addrNibble = pc[3:0];
      CYC_A2:  addrNibble = pc[7:4];
      CYC_A3:  addrNibble = pc[11:8];
      default: addrNibble = 4'h0;
    endcase
  end

  assign syncOut = (cycle == CYC_X3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= PC_RESET;
      opr           <= 4'h0;
      opa           <= 4'h0;
      word2         <= 8'h00;
      twoWord       <= 1'b0;
      instrValid    <= 1'b0;
      secondPending <= 1'b0;
    end else begin
      instrValid <= 1'b0;
      case (cycle)
        CYC_M1: begin
          if (secondPending) word2[7:4] <= romData;
          else               opr        <= romData;
        end
        CYC_M2: begin
          if (secondPending) begin
            word2[3:0] <= romData;
            instrValid <= 1'b1;
          end else begin
            opa           <= romData;
            twoWord       <= firstIsTwo;
            secondPending <= firstIsTwo;
            instrValid    <= ~firstIsTwo;
          end
        end
        CYC_X1: begin
          // A strobe while pending means this was the second word.
          if (instrValid && secondPending) secondPending <= 1'b0;
        end
        CYC_X3: begin
          if (jumpEn) begin
            pc            <= jumpAddr;
            secondPending <= 1'b0;
          end else begin
            pc <= pc + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: instruction-level reference model fed from a byte ROM array.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cycle;
  logic [3:0]  romData;
  logic        jumpEn;
  logic [11:0] jumpAddr;
  logic [11:0] pc;
  logic [3:0]  addrNibble;
  logic        syncOut;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  word2;
  logic        twoWord;
  logic        instrValid;

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0]  rom [0:4095];
  logic [11:0] mPc;
  logic        mPending;
  logic [3:0]  mOpr;
  logic [3:0]  mOpa;
  logic [7:0]  mWord2;
  logic        mTwo;

  cpu_fetch_unit #(.PC_RESET(12'h000)) dut (
    .clk(clk), .rst(rst), .cycle(cycle), .romData(romData),
    .jumpEn(jumpEn), .jumpAddr(jumpAddr), .pc(pc), .addrNibble(addrNibble),
    .syncOut(syncOut), .opr(opr), .opa(opa), .word2(word2),
    .twoWord(twoWord), .instrValid(instrValid)
  );

  always #5 clk = ~clk;

  function automatic logic refTwo(input logic [7:0] b);
    return (b[7:4] inside {4'h1, 4'h4, 4'h5, 4'h7}) || (b[7:4] == 4'h2 && b[0] == 1'b0);
  endfunction

  // One full instruction cycle (A1..X3). rstAt in 0..7 asserts rst at that cycle and aborts.
  task automatic runInstr(input logic jEn, input logic [11:0] jAddr, input logic jEarly, input int rstAt);
    logic [11:0] fa;
    logic [11:0] sh;
    logic [7:0]  b;
    logic        expValid;
    logic [3:0]  nOpr, nOpa;
    logic [7:0]  nWord2;
    logic        nTwo, nPend;
    fa = 12'h000;
    b  = rom[mPc];
    nOpr = mOpr; nOpa = mOpa; nWord2 = mWord2; nTwo = mTwo;
    if (!mPending) begin
      nOpr = b[7:4]; nOpa = b[3:0]; nTwo = refTwo(b);
      nPend = nTwo; expValid = !nTwo;
    end else begin
      nWord2 = b; nPend = 1'b0; expValid = 1'b1;
    end
    for (int c = 0; c < 8; c++) begin
      cycle    = c[2:0];
      rst      = (c == rstAt);
      jumpEn   = (c == 7) ? jEn : jEarly;
      jumpAddr = (c == 7 || jEarly) ? jAddr : 12'($urandom);
      romData  = (c == 3) ? rom[fa][7:4] : (c == 4) ? rom[fa][3:0] : 4'($urandom);
      @(negedge clk);
      nChecks++;
      if (syncOut !== (c == 7)) begin
        nErrors++; $display("FAIL syncOut c=%0d got=%b want=%b", c, syncOut, (c == 7));
      end
      nChecks++;
      if (pc !== mPc) begin
        nErrors++; $display("FAIL pc c=%0d got=%h want=%h", c, pc, mPc);
      end
      sh = (c < 3) ? (mPc >> (4 * c)) : 12'h000;
      nChecks++;
      if (addrNibble !== sh[3:0]) begin
        nErrors++; $display("FAIL addrNibble c=%0d got=%h want=%h", c, addrNibble, sh[3:0]);
      end
      if (c < 3) fa[4*c +: 4] = addrNibble;
      nChecks++;
      if (instrValid !== (c == 5 && expValid)) begin
        nErrors++; $display("FAIL instrValid c=%0d got=%b want=%b", c, instrValid, (c == 5 && expValid));
      end
      if (c == 5 && expValid) begin
        nChecks++;
        if ({opr, opa, word2, twoWord} !== {nOpr, nOpa, nWord2, nTwo}) begin
          nErrors++;
          $display("FAIL instr got opr=%h opa=%h word2=%h two=%b want opr=%h opa=%h word2=%h two=%b",
                   opr, opa, word2, twoWord, nOpr, nOpa, nWord2, nTwo);
        end
      end
      @(posedge clk); #1;
      if (c == rstAt) begin
        rst = 1'b0;
        mPc = 12'h000; mPending = 1'b0;
        mOpr = 4'h0; mOpa = 4'h0; mWord2 = 8'h00; mTwo = 1'b0;
        nChecks++;
        if ({pc, opr, opa, word2, twoWord, instrValid} !== 30'd0) begin
          nErrors++;
          $display("FAIL midReset got pc=%h opr=%h opa=%h word2=%h two=%b vld=%b want all zero",
                   pc, opr, opa, word2, twoWord, instrValid);
        end
        return;
      end
    end
    mOpr = nOpr; mOpa = nOpa; mWord2 = nWord2; mTwo = nTwo; mPending = nPend;
    if (jEn) begin
      mPc = jAddr; mPending = 1'b0;
    end else begin
      mPc = mPc + 12'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; jumpEn = 1'b1; jumpAddr = 12'hABC; romData = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cycle = 3'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    mPc = 12'h000; mPending = 1'b0; mOpr = 4'h0; mOpa = 4'h0; mWord2 = 8'h00; mTwo = 1'b0;
    nChecks++;
    if (pc !== 12'h000) begin nErrors++; $display("FAIL reset_pc got=%h want=000", pc); end
    nChecks++;
    if ({opr, opa} !== 8'h00) begin nErrors++; $display("FAIL reset_opr_opa got=%h want=00", {opr, opa}); end
    nChecks++;
    if (word2 !== 8'h00) begin nErrors++; $display("FAIL reset_word2 got=%h want=00", word2); end
    nChecks++;
    if ({twoWord, instrValid} !== 2'b00) begin
      nErrors++; $display("FAIL reset_flags got=%b want=00", {twoWord, instrValid});
    end
  endtask

  task automatic test_ldm();
    rom[12'h000] = 8'hD5;
    runInstr(1'b0, 12'h000, 1'b0, -1);
    nChecks++;
    if (pc !== 12'h001) begin nErrors++; $display("FAIL ldm_pc got=%h want=001", pc); end
  endtask

  task automatic test_jun();
    rom[12'h001] = 8'hD0;
    runInstr(1'b1, 12'h010, 1'b0, -1);
    rom[12'h010] = 8'h40;
    rom[12'h011] = 8'h23;
    runInstr(1'b0, 12'h000, 1'b0, -1);
    runInstr(1'b1, 12'h023, 1'b0, -1);
    nChecks++;
    if ({pc, opr, opa, word2, twoWord} !== {12'h023, 4'h4, 4'h0, 8'h23, 1'b1}) begin
      nErrors++;
      $display("FAIL jun got pc=%h opr=%h opa=%h word2=%h two=%b want 023 4 0 23 1", pc, opr, opa, word2, twoWord);
    end
  endtask

  task automatic test_wrap();
    rom[12'h023] = 8'hD1;
    runInstr(1'b1, 12'hFFF, 1'b0, -1);
    rom[12'hFFF] = 8'hD7;
    runInstr(1'b0, 12'h000, 1'b0, -1);
    nChecks++;
    if (pc !== 12'h000) begin nErrors++; $display("FAIL wrap_pc got=%h want=000", pc); end
  endtask

  task automatic test_jump_ignore();
    rom[12'h000] = 8'hD5;
    runInstr(1'b0, 12'h5A5, 1'b1, -1);
    nChecks++;
    if (pc !== 12'h001) begin nErrors++; $display("FAIL jump_early got=%h want=001", pc); end
    rom[12'h001] = 8'hD0;
    runInstr(1'b1, 12'h5A5, 1'b1, -1);
    nChecks++;
    if (pc !== 12'h5A5) begin nErrors++; $display("FAIL jump_taken got=%h want=5a5", pc); end
  endtask

  task automatic test_fim_flush();
    rom[12'h5A5] = 8'h24;
    runInstr(1'b1, 12'h100, 1'b0, -1);
    rom[12'h100] = 8'hD9;
    runInstr(1'b0, 12'h000, 1'b0, -1);
    nChecks++;
    if ({opr, opa, twoWord} !== {4'hD, 4'h9, 1'b0}) begin
      nErrors++; $display("FAIL fim_flush got opr=%h opa=%h two=%b want D 9 0", opr, opa, twoWord);
    end
  endtask

  task automatic test_reset_mid();
    rom[12'h101] = 8'h52;
    runInstr(1'b0, 12'h000, 1'b0, 4);
    rom[12'h000] = 8'hD5;
    runInstr(1'b0, 12'h000, 1'b0, -1);
    nChecks++;
    if ({opr, opa, twoWord} !== {4'hD, 4'h5, 1'b0}) begin
      nErrors++; $display("FAIL reset_mid_next got opr=%h opa=%h two=%b want D 5 0", opr, opa, twoWord);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rom[mPc] = 8'($urandom);
      if ($urandom_range(3) == 0) rom[mPc][7:4] = 4'($urandom_range(7));  // bias toward two-word codes
      runInstr(($urandom_range(3) == 0), 12'($urandom), 1'($urandom_range(1)),
               ($urandom_range(40) == 0) ? int'($urandom_range(7)) : -1);
    end
  endtask

  initial begin
    rst = 1'b1; cycle = 3'd0; romData = 4'h0; jumpEn = 1'b0; jumpAddr = 12'h000;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    test_reset();
    test_ldm();
    test_jun();
    test_wrap();
    test_jump_ignore();
    test_fim_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
